// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: default sizing, direction encoding and the
// per-pin edge-event helper used by the input conditioner.
package gpio_pkg;

    localparam int   GPIO_N_DEFAULT           = 8;
    localparam int   GPIO_DB_CNT_W_DEFAULT    = 4;
    localparam int   GPIO_SYNC_STAGES_DEFAULT = 2;

    // Direction bit value meaning "pin is an input"; GPIO core uses the same encoding.
    localparam logic DIR_INPUT = 1'b1;

    // One-cycle edge event for a single pin: only input pins report edges.
    function automatic logic edge_event(
        input logic cur,
        input logic prev,
        input logic dir,
        input logic rise_en,
        input logic fall_en
    );
        logic is_input;
        is_input = (dir == DIR_INPUT);
        return is_input & ((cur & ~prev & rise_en) | (~cur & prev & fall_en));
    endfunction

endpackage

// File: rtl/gpio_pin_filter.sv
// Single-pin front end: metastability synchroniser followed by a
// mismatch-counting debouncer that produces the clean pin level.
module gpio_pin_filter
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,  // must be >= 2
    parameter int DB_CNT_W    = GPIO_DB_CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pad,
    input  logic [DB_CNT_W-1:0] db_limit,
    output logic                clean
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [DB_CNT_W-1:0]    cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: pad enters at bit 0, sync taken from the last stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    // Debounce: count consecutive mismatch cycles, accept the new level once
    // the count reaches db_limit. The >= compare means a db_limit lowered
    // below the running count accepts on the next mismatch, and cnt never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean <= 1'b0;
            cnt   <= '0;
        end else if (sync == clean) begin
            cnt   <= '0;
        end else if (cnt >= db_limit) begin
            clean <= sync;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + DB_CNT_W'(1);
        end
    end

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin synchronise + debounce, then edge
// detection on input pins into sticky interrupt status and a combined irq.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int N           = GPIO_N_DEFAULT,
    parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT,
    parameter int DB_CNT_W    = GPIO_DB_CNT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N-1:0]        pad_in,
    input  logic [N-1:0]        gpio_direction,
    input  logic [DB_CNT_W-1:0] db_limit,
    input  logic [N-1:0]        rise_en,
    input  logic [N-1:0]        fall_en,
    input  logic [N-1:0]        irq_clear,
    output logic [N-1:0]        gpio_in_clean,
    output logic [N-1:0]        irq_status,
    output logic                irq
);

    logic [N-1:0] clean;
    logic [N-1:0] clean_d;
    logic [N-1:0] evt;

    for (genvar i = 0; i < N; i++) begin : g_pin
        gpio_pin_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CNT_W    (DB_CNT_W)
        ) u_filt (
            .clk      (clk),
            .reset_n  (reset_n),
            .pad      (pad_in[i]),
            .db_limit (db_limit),
            .clean    (clean[i])
        );

        assign evt[i] = edge_event(clean[i], clean_d[i], gpio_direction[i],
                                   rise_en[i], fall_en[i]);
    end

    assign gpio_in_clean = clean;

    // Previous clean level, the reference for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clean_d <= '0;
        end else begin
            clean_d <= clean;
        end
    end

    // Sticky status: clear first, then OR in new events so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clear) | evt;
        end
    end

    assign irq = |irq_status;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner. Each scenario pushes
// expected (tick, clean, status) records into a scoreboard queue as it
// drives stimulus, and pops/compares them when the run reaches that tick.
module tb_gpio_input_conditioner;

    logic       clk;
    logic       reset_n;
    logic [7:0] pad_in;
    logic [7:0] gpio_direction;
    logic [3:0] db_limit;
    logic [7:0] rise_en;
    logic [7:0] fall_en;
    logic [7:0] irq_clear;
    logic [7:0] gpio_in_clean;
    logic [7:0] irq_status;
    logic       irq;

    typedef struct {
        int         at;
        logic [7:0] clean;
        logic [7:0] stat;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    gpio_input_conditioner dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pad_in         (pad_in),
        .gpio_direction (gpio_direction),
        .db_limit       (db_limit),
        .rise_en        (rise_en),
        .fall_en        (fall_en),
        .irq_clear      (irq_clear),
        .gpio_in_clean  (gpio_in_clean),
        .irq_status     (irq_status),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        int   t;
        reset_n = 1'b0; pad_in = 8'hFF; gpio_direction = 8'hFF; rise_en = 8'hFF;
        fall_en = 8'h00; irq_clear = 8'h00; db_limit = 4'd3;
        repeat (3) tick();
        checks++;
        if (gpio_in_clean !== 8'h00 || irq_status !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: clean=%h stat=%h irq=%b want 00 00 0",
                     gpio_in_clean, irq_status, irq);
        end
        reset_n = 1'b1;
        sb.push_back('{5, 8'h00, 8'h00, "rst_pre"});
        sb.push_back('{6, 8'hFF, 8'h00, "rst_clean"});
        sb.push_back('{7, 8'hFF, 8'hFF, "rst_irq"});
        t = 0;
        while (t < 8) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   t;
        pad_in = 8'h00; rise_en = 8'h00; fall_en = 8'h00; db_limit = 4'd3;
        irq_clear = 8'hFF;
        tick();
        irq_clear = 8'h00;
        repeat (8) tick();
        foreach (sb[k]) sb.delete(k);
        sb.push_back('{3,  8'h00, 8'h00, "g3_a"});
        sb.push_back('{6,  8'h00, 8'h00, "g3_b"});
        sb.push_back('{8,  8'h00, 8'h00, "g3_c"});
        sb.push_back('{12, 8'h00, 8'h00, "g3_d"});
        sb.push_back('{25, 8'h00, 8'h00, "g4_pre"});
        sb.push_back('{26, 8'h01, 8'h00, "g4_rise"});
        sb.push_back('{29, 8'h01, 8'h00, "g4_hold"});
        sb.push_back('{30, 8'h00, 8'h00, "g4_fall"});
        pad_in = 8'h01;
        t = 0;
        while (t < 32) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
            case (t)
                3:  pad_in = 8'h00;
                20: pad_in = 8'h01;
                24: pad_in = 8'h00;
                default: ;
            endcase
        end
    endtask

    task automatic test_direction();
        exp_t e;
        int   t;
        gpio_direction = 8'h0F; rise_en = 8'hFF; fall_en = 8'h00; db_limit = 4'd0;
        sb.push_back('{2, 8'h00, 8'h00, "dir_pre"});
        sb.push_back('{3, 8'hFF, 8'h00, "dir_clean"});
        sb.push_back('{4, 8'hFF, 8'h0F, "dir_mask"});
        sb.push_back('{6, 8'hFF, 8'h00, "dir_clear"});
        pad_in = 8'hFF;
        t = 0;
        while (t < 7) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
            case (t)
                5: irq_clear = 8'hFF;
                6: irq_clear = 8'h00;
                default: ;
            endcase
        end
    endtask

    task automatic test_fall_set_clear();
        exp_t e;
        int   t;
        gpio_direction = 8'hFF; rise_en = 8'h00; fall_en = 8'h04; db_limit = 4'd0;
        sb.push_back('{3,  8'hFB, 8'h00, "f1_clean"});
        sb.push_back('{4,  8'hFB, 8'h04, "f1_set"});
        sb.push_back('{7,  8'hFF, 8'h04, "f_rerise"});
        sb.push_back('{10, 8'hFB, 8'h04, "f2_clean"});
        sb.push_back('{11, 8'hFB, 8'h04, "f_set_wins"});
        sb.push_back('{13, 8'hFB, 8'h00, "f_clear"});
        pad_in = 8'hFB;
        t = 0;
        while (t < 14) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
            case (t)
                4:  pad_in = 8'hFF;
                7:  pad_in = 8'hFB;
                10: irq_clear = 8'h04;
                11: irq_clear = 8'h00;
                12: irq_clear = 8'h04;
                13: irq_clear = 8'h00;
                default: ;
            endcase
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int   t;
        gpio_direction = 8'hFF; rise_en = 8'hFF; fall_en = 8'h00; db_limit = 4'd10;
        sb.push_back('{7, 8'hFB, 8'h00, "mr_pre"});
        pad_in = 8'hFF;
        t = 0;
        while (t < 7) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
        end
        // Counter is at 5 here; reset lands between clock edges.
        reset_n = 1'b0;
        #1;
        checks++;
        if (gpio_in_clean !== 8'h00 || irq_status !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mr_async: clean=%h stat=%h irq=%b want 00 00 0",
                     gpio_in_clean, irq_status, irq);
        end
        tick();
        reset_n = 1'b1;
        sb.push_back('{12, 8'h00, 8'h00, "mr_pre_lat"});
        sb.push_back('{13, 8'hFF, 8'h00, "mr_lat12"});
        sb.push_back('{14, 8'hFF, 8'hFF, "mr_rise"});
        t = 0;
        while (t < 15) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
        end
    endtask

    task automatic test_db0_follow();
        exp_t       e;
        int         t;
        logic [7:0] p;
        rise_en = 8'h00; fall_en = 8'h00; db_limit = 4'd0;
        irq_clear = 8'hFF;
        tick();
        irq_clear = 8'h00;
        sb.push_back('{1, 8'hFF, 8'h00, "db0_hold1"});
        sb.push_back('{2, 8'hFF, 8'h00, "db0_hold2"});
        t = 0;
        p = 8'($urandom_range(0, 255));
        pad_in = p;
        sb.push_back('{3, p, 8'h00, "db0_follow"});
        while (t < 27) begin
            tick(); t++;
            while (sb.size() > 0 && sb[0].at <= t) begin
                e = sb.pop_front();
                checks++;
                if (gpio_in_clean !== e.clean || irq_status !== e.stat || irq !== (|e.stat)) begin
                    errors++;
                    $display("FAIL %s t=%0d: clean=%h stat=%h irq=%b want clean=%h stat=%h irq=%b",
                             e.tag, t, gpio_in_clean, irq_status, irq, e.clean, e.stat, |e.stat);
                end
            end
            if (t < 24) begin
                p = 8'($urandom_range(0, 255));
                pad_in = p;
                sb.push_back('{t + 3, p, 8'h00, "db0_follow"});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_glitch();
        test_direction();
        test_fall_set_clear();
        test_mid_reset();
        test_db0_follow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
